// File: rtl/fiber_pkg.sv
// Shared request encodings and FSM state constants for the fiber cache front end.
package fiber_pkg;

  localparam int unsigned REQ_TYPE_W = 4;

  localparam logic [REQ_TYPE_W-1:0] FETCH_REQ   = 4'b0001;
  localparam logic [REQ_TYPE_W-1:0] READ_REQ    = 4'b0010;
  localparam logic [REQ_TYPE_W-1:0] WRITE_REQ   = 4'b0100;
  localparam logic [REQ_TYPE_W-1:0] CONSUME_REQ = 4'b1000;

  typedef logic [0:0] fiber_state_e;
  localparam fiber_state_e IDLE  = 1'b0;
  localparam fiber_state_e ISSUE = 1'b1;

endpackage

// File: rtl/fiber_id_fifo.sv
// In-order FIFO of requester IDs for outstanding READs; head steers returned data.
module fiber_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_nreset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fiber_req_arbiter.sv
// Round-robin arbiter sharing the fiber cache request port among NUM_PE requesters,
// with in-order steering of returned READ data back to the issuing PE.
module fiber_req_arbiter
  import fiber_pkg::*;
#(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RD_DEPTH   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_nreset,
  input  logic [NUM_PE*REQ_TYPE_W-1:0]   i_pe_request_type,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]   i_pe_addr,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   i_pe_data,
  input  logic [NUM_PE-1:0]              i_pe_type_valid,
  output logic [NUM_PE-1:0]              o_pe_type_ready,
  output logic [DATA_WIDTH-1:0]          o_pe_data_o,
  output logic [NUM_PE-1:0]              o_pe_data_o_valid,
  input  logic [NUM_PE-1:0]              i_pe_data_o_ready,
  output logic [REQ_TYPE_W-1:0]          o_request_type,
  output logic [ADDR_WIDTH-1:0]          o_addr,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_type_valid,
  input  logic                           i_type_ready,
  input  logic [DATA_WIDTH-1:0]          i_cache_data,
  input  logic                           i_cache_data_valid,
  output logic                           o_cache_data_ready,
  output logic                           o_orphan
);

  localparam int unsigned IDW = $clog2(NUM_PE);

  fiber_state_e            state_q, state_d;
  logic [IDW-1:0]          last_grant_q, last_grant_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [REQ_TYPE_W-1:0]   req_type_q, req_type_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    orphan_q, orphan_d;

  logic [REQ_TYPE_W-1:0]   pe_type_a [NUM_PE];
  logic [ADDR_WIDTH-1:0]   pe_addr_a [NUM_PE];
  logic [DATA_WIDTH-1:0]   pe_data_a [NUM_PE];
  logic [NUM_PE-1:0]       eligible;
  logic                    win_found;
  logic [IDW-1:0]          win_id;
  int unsigned             cand;
  logic [IDW-1:0]          cand_id;

  logic [NUM_PE-1:0]       pe_ready_c;
  logic [NUM_PE-1:0]       pe_dvalid_c;
  logic [DATA_WIDTH-1:0]   pe_dout_c;
  logic                    cache_ready_c;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDW-1:0]          fifo_head;

  // A READ is only eligible while the ID FIFO has room for its return slot.
  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    assign pe_type_a[k] = i_pe_request_type[k*REQ_TYPE_W +: REQ_TYPE_W];
    assign pe_addr_a[k] = i_pe_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign pe_data_a[k] = i_pe_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign eligible[k]  = i_pe_type_valid[k] &
                          ((pe_type_a[k] != READ_REQ) | ~fifo_full);
  end

  // Round-robin search upward from last_grant+1, wrapping at NUM_PE.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned i = 1; i <= NUM_PE; i++) begin
      cand    = (32'(last_grant_q) + i) % NUM_PE;
      cand_id = IDW'(cand);
      if (!win_found && eligible[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    req_type_d   = req_type_q;
    addr_d       = addr_q;
    data_d       = data_q;
    fifo_push    = 1'b0;
    pe_ready_c   = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          id_d       = win_id;
          req_type_d = pe_type_a[win_id];
          addr_d     = pe_addr_a[win_id];
          data_d     = pe_data_a[win_id];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (i_type_ready) begin
          pe_ready_c[id_q] = 1'b1;
          last_grant_d     = id_q;
          fifo_push        = (req_type_q == READ_REQ);
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return path is purely combinational; data with nothing outstanding is flagged.
  always_comb begin
    pe_dout_c     = '0;
    pe_dvalid_c   = '0;
    cache_ready_c = 1'b0;
    orphan_d      = orphan_q;
    if (!fifo_empty) begin
      pe_dout_c              = i_cache_data;
      pe_dvalid_c[fifo_head] = i_cache_data_valid;
      cache_ready_c          = i_pe_data_o_ready[fifo_head];
    end else if (i_cache_data_valid) begin
      orphan_d = 1'b1;
    end
  end

  assign fifo_pop = i_cache_data_valid & cache_ready_c;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_PE - 1);
      id_q         <= '0;
      req_type_q   <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      orphan_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      req_type_q   <= req_type_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      orphan_q     <= orphan_d;
    end
  end

  fiber_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (RD_DEPTH)
  ) u_id_fifo (
    .i_clk    (i_clk),
    .i_nreset (i_nreset),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .data_i   (id_q),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .head_o   (fifo_head)
  );

  assign o_type_valid       = (state_q == ISSUE);
  assign o_request_type     = req_type_q;
  assign o_addr             = addr_q;
  assign o_data             = data_q;
  assign o_orphan           = orphan_q;
  assign o_pe_type_ready    = pe_ready_c;
  assign o_pe_data_o        = pe_dout_c;
  assign o_pe_data_o_valid  = pe_dvalid_c;
  assign o_cache_data_ready = cache_ready_c;

endmodule

// File: tb/tb_fiber_req_arbiter.sv
// Directed bench for fiber_req_arbiter: vector table for arbitration, hand sequences for FIFO/return/reset.
module tb_fiber_req_arbiter;

  logic          clk;
  logic          rst_n;
  logic [15:0]   pe_type;
  logic [255:0]  pe_addr;
  logic [63:0]   pe_data;
  logic [3:0]    pe_valid;
  logic [3:0]    pe_ready;
  logic [15:0]   pe_dout;
  logic [3:0]    pe_dvalid;
  logic [3:0]    pe_dready;
  logic [3:0]    rtype;
  logic [63:0]   addr;
  logic [15:0]   data;
  logic          tv;
  logic          tr;
  logic [15:0]   cdata;
  logic          cvalid;
  logic          cready;
  logic          orphan;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] types;
    logic        tr;
    logic        etv;
    logic [1:0]  eid;
    logic [3:0]  etype;
    logic [3:0]  erdy;
  } vec_t;

  vec_t vecs[$];

  fiber_req_arbiter #(
    .NUM_PE(4), .ADDR_WIDTH(64), .DATA_WIDTH(16), .RD_DEPTH(4)
  ) dut (
    .i_clk              (clk),
    .i_nreset           (rst_n),
    .i_pe_request_type  (pe_type),
    .i_pe_addr          (pe_addr),
    .i_pe_data          (pe_data),
    .i_pe_type_valid    (pe_valid),
    .o_pe_type_ready    (pe_ready),
    .o_pe_data_o        (pe_dout),
    .o_pe_data_o_valid  (pe_dvalid),
    .i_pe_data_o_ready  (pe_dready),
    .o_request_type     (rtype),
    .o_addr             (addr),
    .o_data             (data),
    .o_type_valid       (tv),
    .i_type_ready       (tr),
    .i_cache_data       (cdata),
    .i_cache_data_valid (cvalid),
    .o_cache_data_ready (cready),
    .o_orphan           (orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_addr(input logic [1:0] k);
    return 64'hA5A5_0000_0000_0000 | (64'(k) << 8);
  endfunction

  function automatic logic [15:0] exp_data(input logic [1:0] k);
    return 16'hD000 | 16'(k);
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] t, input logic r,
                              input logic etv, input logic [1:0] eid,
                              input logic [3:0] etype, input logic [3:0] erdy);
    vec_t x;
    x.valid = v; x.types = t; x.tr = r;
    x.etv = etv; x.eid = eid; x.etype = etype; x.erdy = erdy;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " tv"},     64'(tv), 64'd0);
    chk({tag, " rtype"},  64'(rtype), 64'd0);
    chk({tag, " addr"},   addr, 64'd0);
    chk({tag, " data"},   64'(data), 64'd0);
    chk({tag, " ready"},  64'(pe_ready), 64'd0);
    chk({tag, " dvalid"}, 64'(pe_dvalid), 64'd0);
    chk({tag, " cready"}, 64'(cready), 64'd0);
    chk({tag, " dout"},   64'(pe_dout), 64'd0);
    chk({tag, " orphan"}, 64'(orphan), 64'd0);
  endtask

  // Raise PE k with type t and wait (bounded) for its ready pulse; drop valid once granted.
  task automatic do_req(input int k, input logic [3:0] t, input int budget, output bit got);
    got = 1'b0;
    pe_type[k*4 +: 4] = t;
    pe_valid[k] = 1'b1;
    tr = 1'b1;
    for (int c = 0; c < budget && !got; c++) begin
      #2;
      if (pe_ready[k]) got = 1'b1;
      @(negedge clk);
    end
    if (got) pe_valid[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit g;
    rst_n = 1'b0; pe_type = '0; pe_valid = '0; pe_dready = '0;
    tr = 1'b0; cdata = '0; cvalid = 1'b0; pe_data = '0; pe_addr = '0;
    for (int k = 0; k < 4; k++) begin
      pe_addr[k*64 +: 64] = exp_addr(2'(k));
      pe_data[k*16 +: 16] = exp_data(2'(k));
    end

    // Four FETCHes in parallel, then round-robin after last_grant=2 with a stall.
    vecs.push_back(mk(4'b1111, 16'h1111, 1, 0, 0, 4'h0, 4'b0000));
    vecs.push_back(mk(4'b1111, 16'h1111, 1, 1, 0, 4'h1, 4'b0001));
    vecs.push_back(mk(4'b1110, 16'h1111, 1, 0, 0, 4'h0, 4'b0000));
    vecs.push_back(mk(4'b1110, 16'h1111, 1, 1, 1, 4'h1, 4'b0010));
    vecs.push_back(mk(4'b1100, 16'h1111, 1, 0, 0, 4'h0, 4'b0000));
    vecs.push_back(mk(4'b1100, 16'h1111, 1, 1, 2, 4'h1, 4'b0100));
    vecs.push_back(mk(4'b1000, 16'h1111, 1, 0, 0, 4'h0, 4'b0000));
    vecs.push_back(mk(4'b1000, 16'h1111, 1, 1, 3, 4'h1, 4'b1000));
    vecs.push_back(mk(4'b0000, 16'h1111, 1, 0, 0, 4'h0, 4'b0000));
    vecs.push_back(mk(4'b0100, 16'h1481, 1, 0, 0, 4'h0, 4'b0000));
    vecs.push_back(mk(4'b0100, 16'h1481, 1, 1, 2, 4'h4, 4'b0100));
    vecs.push_back(mk(4'b1010, 16'h1481, 1, 0, 0, 4'h0, 4'b0000));
    vecs.push_back(mk(4'b1010, 16'h1481, 0, 1, 3, 4'h1, 4'b0000));
    vecs.push_back(mk(4'b1010, 16'h1481, 0, 1, 3, 4'h1, 4'b0000));
    vecs.push_back(mk(4'b1010, 16'h1481, 1, 1, 3, 4'h1, 4'b1000));
    vecs.push_back(mk(4'b0010, 16'h1481, 1, 0, 0, 4'h0, 4'b0000));
    vecs.push_back(mk(4'b0010, 16'h1481, 1, 1, 1, 4'h8, 4'b0010));
    vecs.push_back(mk(4'b0000, 16'h1481, 1, 0, 0, 4'h0, 4'b0000));

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      pe_valid = vecs[i].valid;
      pe_type  = vecs[i].types;
      tr       = vecs[i].tr;
      #2;
      chk($sformatf("row%0d tv", i), 64'(tv), 64'(vecs[i].etv));
      chk($sformatf("row%0d ready", i), 64'(pe_ready), 64'(vecs[i].erdy));
      if (vecs[i].etv) begin
        chk($sformatf("row%0d type", i), 64'(rtype), 64'(vecs[i].etype));
        chk($sformatf("row%0d addr", i), addr, exp_addr(vecs[i].eid));
        chk($sformatf("row%0d data", i), 64'(data), 64'(exp_data(vecs[i].eid)));
      end
      @(negedge clk);
    end
    pe_type = '0;

    // Fill the 4-deep ID FIFO, then a 5th READ must stall while a WRITE still goes.
    for (int k = 0; k < 4; k++) begin
      do_req(k, 4'b0010, 4, g);
      chk($sformatf("fill rd%0d grant", k), 64'(g), 64'd1);
    end
    do_req(0, 4'b0010, 6, g);
    chk("5th read stalled", 64'(g), 64'd0);
    #2;
    chk("5th read no valid", 64'(tv), 64'd0);
    @(negedge clk);
    do_req(2, 4'b0100, 4, g);
    chk("write while full", 64'(g), 64'd1);
    cvalid = 1'b1; cdata = 16'h1234; pe_dready = 4'b0001;
    #2;
    chk("pop dvalid", 64'(pe_dvalid), 64'h1);
    chk("pop cready", 64'(cready), 64'd1);
    chk("pop dout", 64'(pe_dout), 64'h1234);
    @(negedge clk);
    cvalid = 1'b0;
    do_req(0, 4'b0010, 4, g);
    chk("5th read admitted", 64'(g), 64'd1);
    for (int j = 0; j < 4; j++) begin
      logic [3:0] ord;
      ord = (j == 0) ? 4'b0010 : (j == 1) ? 4'b0100 : (j == 2) ? 4'b1000 : 4'b0001;
      cvalid = 1'b1; cdata = 16'h0100 + 16'(j); pe_dready = 4'b1111;
      #2;
      chk($sformatf("drain%0d dvalid", j), 64'(pe_dvalid), 64'(ord));
      chk($sformatf("drain%0d cready", j), 64'(cready), 64'd1);
      @(negedge clk);
    end
    cvalid = 1'b0;

    // READs from PE1 then PE3; PE1 back-pressures its data for 3 cycles.
    do_req(1, 4'b0010, 4, g);
    chk("rd pe1 grant", 64'(g), 64'd1);
    do_req(3, 4'b0010, 4, g);
    chk("rd pe3 grant", 64'(g), 64'd1);
    for (int c = 0; c < 3; c++) begin
      cvalid = 1'b1; cdata = 16'hAAAA; pe_dready = 4'b1101;
      #2;
      chk($sformatf("hold%0d dvalid", c), 64'(pe_dvalid), 64'b0010);
      chk($sformatf("hold%0d cready", c), 64'(cready), 64'd0);
      chk($sformatf("hold%0d dout", c), 64'(pe_dout), 64'hAAAA);
      @(negedge clk);
    end
    pe_dready = 4'b1111;
    #2;
    chk("aaaa dvalid", 64'(pe_dvalid), 64'b0010);
    chk("aaaa cready", 64'(cready), 64'd1);
    @(negedge clk);
    cdata = 16'h5555;
    #2;
    chk("5555 dvalid", 64'(pe_dvalid), 64'b1000);
    chk("5555 dout", 64'(pe_dout), 64'h5555);
    chk("5555 cready", 64'(cready), 64'd1);
    @(negedge clk);
    cvalid = 1'b0;
    #2;
    chk("empty dvalid", 64'(pe_dvalid), 64'd0);
    chk("empty cready", 64'(cready), 64'd0);
    chk("no orphan yet", 64'(orphan), 64'd0);
    @(negedge clk);

    // Data with nothing outstanding sets a sticky orphan flag.
    cvalid = 1'b1; cdata = 16'hDEAD;
    #2;
    chk("orphan cready", 64'(cready), 64'd0);
    chk("orphan dvalid", 64'(pe_dvalid), 64'd0);
    chk("orphan same cycle", 64'(orphan), 64'd0);
    @(negedge clk);
    cvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("orphan sticky%0d", c), 64'(orphan), 64'd1);
      @(negedge clk);
    end

    // Reset in the middle of ISSUE, then PE0 must win first after release.
    pe_type = 16'h0101; pe_valid = 4'b0100; tr = 1'b0;
    @(negedge clk);
    #2;
    chk("issue pe2 tv", 64'(tv), 64'd1);
    chk("issue pe2 addr", addr, exp_addr(2'd2));
    #1;
    rst_n = 1'b0; tr = 1'b1; cvalid = 1'b1; cdata = 16'hBEEF;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1; cvalid = 1'b0; pe_valid = 4'b0101;
    #2;
    chk("post reset idle", 64'(tv), 64'd0);
    @(negedge clk);
    #2;
    chk("post reset tv", 64'(tv), 64'd1);
    chk("post reset pe0 wins", addr, exp_addr(2'd0));
    chk("post reset ready", 64'(pe_ready), 64'b0001);
    @(negedge clk);
    pe_valid = 4'b0000;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
